// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract arbiter slice.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int   DW     = 4;

endpackage

// File: rtl/adder_subtractor_4bit.sv
// 4-bit ripple adder/subtractor; M=1 subtracts via two's complement.
// bout is the carry for add and the borrow for subtract.
module adder_subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       M,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] bx;
    logic [4:0] c;

    assign bx = b ^ {4{M}};

    always_comb begin
        c    = '0;
        d    = '0;
        c[0] = M;
        for (int i = 0; i < 4; i++) begin
            d[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    // Carry out of a-b+... is the inverse of the borrow.
    assign bout = c[4] ^ M;

endmodule

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after last_grant+1, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % N_REQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one adder_subtractor_4bit between N_REQ requesters: round-robin
// accept, one execute cycle, then a held response until rsp_ready.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [4*N_REQ-1:0]  req_a,
    input  logic [4*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]    req_m,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [3:0]          rsp_d,
    output logic                rsp_bout,
    output logic                busy
);

    state_t           state, state_nxt;
    logic [IDW-1:0]   last_grant;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             accept;

    logic [DW-1:0]    sel_a, sel_b;
    logic             sel_m;

    logic [DW-1:0]    op_a_p0, op_b_p0;
    logic             op_m_p0;
    logic [IDW-1:0]   op_id_p0;

    logic [DW-1:0]    dp_d;
    logic             dp_bout;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign accept    = |grant;
    assign req_ready = grant;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_m = OP_ADD;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DW +: DW];
                sel_b = req_b[i*DW +: DW];
                sel_m = req_m[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(N_REQ - 1);
        end else begin
            state <= state_nxt;
            if (accept) last_grant <= grant_id;
        end
    end

    // Stage p0: operands captured at the handshake, feed the datapath in EXEC
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a_p0  <= sel_a;
            op_b_p0  <= sel_b;
            op_m_p0  <= sel_m;
            op_id_p0 <= grant_id;
        end
    end

    adder_subtractor_4bit u_dp (
        .a    (op_a_p0),
        .b    (op_b_p0),
        .M    (op_m_p0),
        .d    (dp_d),
        .bout (dp_bout)
    );

    // Result stage: registered at the end of EXEC, held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id   <= '0;
            rsp_d    <= '0;
            rsp_bout <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id   <= op_id_p0;
            rsp_d    <= dp_d;
            rsp_bout <= dp_bout;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench: vector table plus hand sequences, scoreboard on responses.
module tb_addsub_arbiter;
    import addsub_pkg::*;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [N-1:0]   req_m;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_id;
    logic [3:0]     rsp_d;
    logic           rsp_bout;
    logic           busy;

    addsub_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_d     (rsp_d),
        .rsp_bout  (rsp_bout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic       chg;
        logic [3:0] ed;
        logic       eb;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] d;
        logic       b;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [3:0] d, input logic b);
        exp_t e;
        e.id = id;
        e.d  = d;
        e.b  = b;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_d", 32'(rsp_d), 32'(e.d));
                check("rsp_bout", 32'(rsp_bout), 32'(e.b));
            end
        end
    end

    task automatic wait_ready(input int id, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input vec_t v);
        logic ok;
        @(posedge clk); #1;
        req_a[4*v.id +: 4] = v.a;
        req_b[4*v.id +: 4] = v.b;
        req_m[v.id]        = v.m;
        req_valid[v.id]    = 1'b1;
        wait_ready(v.id, ok);
        if (ok) begin
            check("ready_onehot", 32'(req_ready), 32'(1 << v.id));
            sb.push_back(mk(v.id, v.ed, v.eb));
            @(posedge clk); #1;
            req_valid[v.id] = 1'b0;
            if (v.chg) req_a[4*v.id +: 4] = 4'd9;
            @(negedge clk);
            check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            check("exec_busy", 32'(busy), 32'd1);
            @(negedge clk);
            check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk);
        end else begin
            req_valid[v.id] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [3:0] hd;
        logic [W-1:0] hid;
        logic       hb;
        int         order[5];
        int         k;
        int         prev;
        int         seen;
        int         g;

        vecs[0] = '{2, 4'd5,  4'd3,  OP_ADD, 1'b0, 4'd8,  1'b0};
        vecs[1] = '{0, 4'd15, 4'd1,  OP_ADD, 1'b0, 4'd0,  1'b1};
        vecs[2] = '{1, 4'd8,  4'd3,  OP_SUB, 1'b0, 4'd5,  1'b0};
        vecs[3] = '{3, 4'd3,  4'd5,  OP_SUB, 1'b0, 4'd14, 1'b1};
        vecs[4] = '{2, 4'd0,  4'd0,  OP_SUB, 1'b0, 4'd0,  1'b0};
        vecs[5] = '{1, 4'd7,  4'd9,  OP_ADD, 1'b0, 4'd0,  1'b1};
        vecs[6] = '{0, 4'd15, 4'd15, OP_ADD, 1'b0, 4'd14, 1'b1};
        vecs[7] = '{3, 4'd9,  4'd9,  OP_SUB, 1'b0, 4'd0,  1'b0};
        vecs[8] = '{1, 4'd6,  4'd2,  OP_SUB, 1'b1, 4'd4,  1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_m     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_d", 32'(rsp_d), 32'd0);
        check("rst_rsp_bout", 32'(rsp_bout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // Fairness: all requesters held valid from reset
        do_reset();
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            req_a[4*i +: 4] = 4'(i);
            req_b[4*i +: 4] = 4'd1;
            req_m[i]        = OP_ADD;
        end
        req_valid = '1;
        k = 0;
        prev = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                check("rr_order", 32'(g), 32'(order[k]));
                if (k > 0) check("rr_spacing", 32'(c - prev), 32'd3);
                sb.push_back(mk(g, 4'(g + 1), 1'b0));
                prev = c;
                k++;
                if (k == 5) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
        end
        check("rr_grant_count", 32'(k), 32'd5);
        repeat (4) @(negedge clk);

        // Backpressure: stall in RESP, requester 3 waiting
        do_reset();
        rsp_ready = 1'b0;
        req_a[4*1 +: 4] = 4'd2; req_b[4*1 +: 4] = 4'd2; req_m[1] = OP_ADD;
        req_a[4*3 +: 4] = 4'd9; req_b[4*3 +: 4] = 4'd4; req_m[3] = OP_SUB;
        req_valid = 4'b1010;
        @(negedge clk);
        check("bp_first_grant", 32'(req_ready), 32'b0010);
        sb.push_back(mk(1, 4'd4, 1'b0));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        hd = rsp_d; hid = rsp_id; hb = rsp_bout;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_d", 32'(rsp_d), 32'(hd));
            check("bp_hold_id", 32'(rsp_id), 32'(hid));
            check("bp_hold_bout", 32'(rsp_bout), 32'(hb));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'b1000);
        sb.push_back(mk(3, 4'd5, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset pulse during EXEC aborts the result
        req_a[4*2 +: 4] = 4'd1; req_b[4*2 +: 4] = 4'd1; req_m[2] = OP_ADD;
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        wait_ready(2, ok);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("abort_in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        req_a[4*0 +: 4] = 4'd4; req_b[4*0 +: 4] = 4'd4; req_m[0] = OP_ADD;
        req_a[4*3 +: 4] = 4'd1; req_b[4*3 +: 4] = 4'd2; req_m[3] = OP_ADD;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        sb.push_back(mk(0, 4'd8, 1'b0));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_second", 32'(req_ready), 32'b1000);
        sb.push_back(mk(3, 4'd3, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer sharing a single `adder_subtractor_4bit` datapath between `N_REQ` requesters. Each requester presents a valid/ready operation: two 4-bit operands and a mode bit. The block grants one request at a time, drives the shared datapath for one cycle, and returns a registered result tagged with the requester index. It sits between the requesting control units and the single arithmetic resource.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(N_REQ)`: requester-ID width. Derived; do not override.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester operation valid.
- `req_ready` out `N_REQ`: per-requester accept; at most one bit high per cycle.
- `req_a` in `4*N_REQ`: operand a, requester i at bits `[4i+3:4i]`.
- `req_b` in `4*N_REQ`: operand b, same packing.
- `req_m` in `N_REQ`: mode per requester; 0 = add, 1 = subtract. This maps to `M` of the datapath.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out `IDW`: index of the requester that owns the result.
- `rsp_d` out 4: result nibble, equal to the datapath's `d`.
- `rsp_bout` out 1: carry/borrow bit, equal to the datapath's `bout`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - When any `req_valid` bit is high, the arbiter selects grant `g`. `g` is the first set bit scanning upward from `last_grant+1`, modulo `N_REQ`.
  - `req_ready[g]` is driven high combinationally in the same cycle. The handshake completes on that edge.
  - On the handshake, latch `req_a[g]`, `req_b[g]`, `req_m[g]` and `g` into the operand registers, and set `last_grant <= g`. Next state is EXEC.
- **EXEC**
  - The operand registers drive the datapath instance.
  - At the clock edge, register `d` and `bout` into `rsp_d` and `rsp_bout`.
  - Next state is RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_d` and `rsp_bout` are held stable.
  - When `rsp_ready` = 1, leave for IDLE.
  - While not in IDLE, all `req_ready` bits are 0 and no request is accepted.
- Requesters must hold their valid and operands until ready. Operands that change after the handshake have no effect.
- Dropping `req_valid` before ready is legal. That requester is simply not granted.
- Arithmetic: 4-bit modulo result exactly as the datapath produces it, with no widening or saturation. Example: 15+1 gives `d`=0, `bout`=1.
- Reset values (async `rst`):
  - state = IDLE.
  - `req_ready` = 0 (all bits).
  - `rsp_valid` = 0.
  - `rsp_id` = 0, `rsp_d` = 0, `rsp_bout` = 0.
  - `busy` = 0.
  - `last_grant` = `N_REQ-1`, so requester 0 has first priority.
- Reset asserted in EXEC or RESP aborts the operation. The result is discarded and never presented.

## Timing
- Accept at edge T0. EXEC runs in cycle T0+1. `rsp_valid` rises after edge T0+2, giving 2-cycle accept-to-response latency.
- Minimum issue interval is 3 cycles, with `rsp_ready` held high.
- `rsp_ready` held low stalls in RESP indefinitely. Outputs stay stable during the stall.
- A request arriving while busy waits. It is arbitrated in the first IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous load every active requester is served once per `N_REQ` grants (fairness).

## Structure
- Package `addsub_pkg`:
  - state enum {IDLE, EXEC, RESP}.
  - `OP_ADD`=1'b0, `OP_SUB`=1'b1.
  - `DW`=4.
- Sub-module `rr_arbiter`: parameterized `N_REQ`. Inputs are the request vector, `last_grant` and an enable. Outputs are a one-hot grant and an encoded index.
- One `adder_subtractor_4bit` instance, driven only from the operand registers.

## Test plan
- Reset, then one request: requester 2 issues a=5, b=3, M=0. Required: `req_ready[2]` in the same cycle, and 2 cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_d`=8, `rsp_bout`=0.
- Overflow and subtract:
  - a=15, b=1, M=0 → `rsp_d`=0, `rsp_bout`=1.
  - a=8, b=3, M=1 → `rsp_d`=5.
  - a=3, b=5, M=1 → `rsp_d`=14.
- All four requesters valid from reset and held: grants occur in order 0,1,2,3,0. Each grant is spaced 3 cycles apart with `rsp_ready`=1.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP. Outputs stay unchanged, `req_ready` stays 0 and `busy`=1. Once `rsp_ready` is raised, the next grant follows 1 cycle later.
- Reset pulse during EXEC: `rsp_valid` never rises for that operation. After reset, requesters 0 and 3 both valid → requester 0 is granted first.
- Operand change after handshake: requester 1 issues a=6, b=2, M=1, then a is changed to 9. Result must be `rsp_d`=4.
